btn_debounce: RTL

Upstream conditioning stage for the LED/counter blocks on the 100 MHz board clock.
- Takes N raw, asynchronous push-button inputs.
- Synchronises and debounces each one.
- Emits per-channel clean level, one-cycle press/release pulses and a one-cycle long-press pulse.
- Outputs drive counter reset/enable and mode selection downstream.

---
 rtl/btn_pkg.sv | 29 ++
 rtl/btn_debounce_ch.sv | 138 +++++++++++++
 rtl/btn_debounce.sv | 53 +++++
 3 files changed

// File: rtl/btn_pkg.sv
// ----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioning block.
//   btn_state_t : per-channel debounce FSM states
//   CLK_HZ      : board clock frequency
//   DEB_10MS    : debounce window of 10 ms at CLK_HZ, in cycles
//   LONG_1S     : long-press threshold of 1 s at CLK_HZ, in cycles
//   cnt_width() : bit width of a counter that must hold the value 'max'
// ----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int CLK_HZ   = 100_000_000;
    localparam int DEB_10MS = 1_000_000;
    localparam int LONG_1S  = 100_000_000;

    // One spare bit on top of $clog2 so that 'max' itself is representable
    // even when it is an exact power of two.
    function automatic int cnt_width(input int max);
        return $clog2(max) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// ----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-flop synchroniser, debounce FSM, debounce and
// hold counters, registered level and pulse outputs.
//   clk        : system clock
//   rst_n      : synchronous reset, active-low
//   raw        : raw asynchronous button input, already polarity-corrected
//                (1 = pressed)
//   level      : debounced level, 1 = pressed
//   rise       : one-cycle pulse on an accepted press
//   fall       : one-cycle pulse on an accepted release
//   long_pulse : one-cycle pulse once per press after LONG_CYCLES held
// ----------------------------------------------------------------------------
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEB_10MS,
    parameter int LONG_CYCLES     = LONG_1S
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_pulse
);

    localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(LONG_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    // Plain 2-bit codes so the state register stays a simple vector in
    // netlists and waveforms, while the values come from the shared enum.
    localparam logic [1:0] S_RELEASED     = RELEASED;
    localparam logic [1:0] S_PRESS_WAIT   = PRESS_WAIT;
    localparam logic [1:0] S_PRESSED      = PRESSED;
    localparam logic [1:0] S_RELEASE_WAIT = RELEASE_WAIT;

    logic              sync1;
    logic              s;
    logic [1:0]        state;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    // Two-flop synchroniser; reset value 0 means "released".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    // Debounce FSM. The pulse outputs default low every cycle so each one
    // is asserted for exactly the cycle following the accepting edge.
    // deb_cnt is cleared on every state change, so it never has to wrap;
    // hold_cnt saturates at LONG_CYCLES, which also guarantees long_pulse
    // cannot fire twice within one press (a release bounce keeps hold_cnt).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_RELEASED;
            deb_cnt    <= '0;
            hold_cnt   <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            rise       <= 1'b0;
            fall       <= 1'b0;
            long_pulse <= 1'b0;

            case (state)
                S_RELEASED: begin
                    if (s) begin
                        state   <= S_PRESS_WAIT;
                        deb_cnt <= '0;
                    end
                end

                S_PRESS_WAIT: begin
                    if (!s) begin
                        state   <= S_RELEASED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state    <= S_PRESSED;
                        deb_cnt  <= '0;
                        hold_cnt <= '0;
                        level    <= 1'b1;
                        rise     <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_ONE;
                    end
                end

                S_PRESSED: begin
                    if (!s) begin
                        state   <= S_RELEASE_WAIT;
                        deb_cnt <= '0;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                        if (hold_cnt == HOLD_LAST) begin
                            long_pulse <= 1'b1;
                        end
                    end
                end

                S_RELEASE_WAIT: begin
                    if (s) begin
                        state   <= S_PRESSED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= S_RELEASED;
                        deb_cnt <= '0;
                        level   <= 1'b0;
                        fall    <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_ONE;
                    end
                end

                default: begin
                    state   <= S_RELEASED;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Synchronises and debounces N_BTN raw push-buttons and produces clean
// per-channel level, press/release pulses and a long-press pulse. All
// outputs are registered.
//   clk       : system clock, 100 MHz
//   rst_n     : synchronous reset, active-low
//   btn_raw   : raw asynchronous button pins
//   btn_level : debounced level, 1 = pressed
//   btn_rise  : one-cycle pulse on accepted press
//   btn_fall  : one-cycle pulse on accepted release
//   btn_long  : one-cycle pulse once per press after LONG_CYCLES held
// ----------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEB_10MS,
    parameter int LONG_CYCLES     = LONG_1S,
    parameter int ACTIVE_HIGH     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic [N_BTN-1:0] btn_long
);

    logic [N_BTN-1:0] raw_pol;

    // A static inverter in front of the first synchroniser flop behaves the
    // same as inverting its output, and keeps the synchroniser reset value
    // meaning "released" for both polarities.
    assign raw_pol = (ACTIVE_HIGH != 0) ? btn_raw : ~btn_raw;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw        (raw_pol[i]),
            .level      (btn_level[i]),
            .rise       (btn_rise[i]),
            .fall       (btn_fall[i]),
            .long_pulse (btn_long[i])
        );
    end

endmodule
